// File: rtl/op_fifo_engine_if.sv
// Register-mapped access bus for op_fifo_engine: one write port and one read port,
// each with its own address, strobe and ready.
interface op_fifo_engine_if #(
  parameter int DATA_W = 8
);
  // Handshake: a write (read) transfers on a rising edge where write_en && write_rdy
  // (read_en && read_rdy). Ready depends only on the address and registered state,
  // never on the strobe. read_data is registered and holds until the next accepted read.
  logic [2:0]        write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic              write_rdy;
  logic [2:0]        read_address;
  logic              read_en;
  logic [DATA_W-1:0] read_data;
  logic              read_rdy;

  modport master (
    output write_address, write_data, write_en, read_address, read_en,
    input  write_rdy, read_data, read_rdy
  );

  modport slave (
    input  write_address, write_data, write_en, read_address, read_en,
    output write_rdy, read_data, read_rdy
  );
endinterface

// File: rtl/op_fifo_engine.sv
// Two-operand engine: operand FIFOs A/B feed a mode-selected op into result FIFO Y.
// Define OP_FIFO_ENGINE_ERR_EN to add the sticky protocol-error register at read address 7.
module op_fifo_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input logic            CLK,
  input logic            RST_N,
  op_fifo_engine_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] b_mem [DEPTH];
  logic [DATA_W-1:0] y_mem [DEPTH];
  logic [PW-1:0]     a_wp, a_rp, b_wp, b_rp, y_wp, y_rp;
  logic [CW-1:0]     a_cnt, b_cnt, y_cnt;
  logic [1:0]        mode;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rd_mux, y_val;

  logic a_full, b_full, y_full, a_empty, b_empty, y_empty;
  logic wr_acc, rd_acc, a_push, b_push, y_pop, fire;

  // Flags come from start-of-cycle counts only, so same-cycle pops never free a slot early.
  assign a_full  = (a_cnt == CW'(DEPTH));
  assign b_full  = (b_cnt == CW'(DEPTH));
  assign y_full  = (y_cnt == CW'(DEPTH));
  assign a_empty = (a_cnt == '0);
  assign b_empty = (b_cnt == '0);
  assign y_empty = (y_cnt == '0);

  assign bus.write_rdy = RST_N && !((bus.write_address == 3'd4 && a_full) ||
                                    (bus.write_address == 3'd5 && b_full));
  assign bus.read_rdy  = RST_N && !(bus.read_address == 3'd3 && y_empty);

  assign wr_acc = bus.write_en && bus.write_rdy;
  assign rd_acc = bus.read_en && bus.read_rdy;
  assign a_push = wr_acc && (bus.write_address == 3'd4);
  assign b_push = wr_acc && (bus.write_address == 3'd5);
  assign y_pop  = rd_acc && (bus.read_address == 3'd3);
  assign fire   = !a_empty && !b_empty && !y_full;

  always_comb begin
    y_val = '0;
    case (mode)
      2'd0: y_val = a_mem[a_rp] | b_mem[b_rp];
      2'd1: y_val = a_mem[a_rp] & b_mem[b_rp];
      2'd2: y_val = a_mem[a_rp] ^ b_mem[b_rp];
      default: y_val = a_mem[a_rp] + b_mem[b_rp];
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (bus.read_address)
      3'd0: rd_mux[0] = !a_full;
      3'd1: rd_mux[0] = !b_full;
      3'd2: rd_mux[0] = !y_empty;
      3'd3: rd_mux = y_mem[y_rp];
      3'd6: rd_mux[1:0] = mode;
      3'd7: rd_mux[1:0] = err_q;
      default: rd_mux = '0;
    endcase
  end

  // Storage carries no reset; counts and pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (a_push) a_mem[a_wp] <= bus.write_data;
    if (b_push) b_mem[b_wp] <= bus.write_data;
    if (fire)   y_mem[y_wp] <= y_val;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_wp <= '0; a_rp <= '0; a_cnt <= '0;
      b_wp <= '0; b_rp <= '0; b_cnt <= '0;
      y_wp <= '0; y_rp <= '0; y_cnt <= '0;
      mode <= 2'd0;
      bus.read_data <= '0;
    end else begin
      if (a_push) a_wp <= a_wp + PW'(1);
      if (b_push) b_wp <= b_wp + PW'(1);
      if (fire) begin
        a_rp <= a_rp + PW'(1);
        b_rp <= b_rp + PW'(1);
        y_wp <= y_wp + PW'(1);
      end
      if (y_pop) y_rp <= y_rp + PW'(1);
      case ({a_push, fire})
        2'b10:   a_cnt <= a_cnt + CW'(1);
        2'b01:   a_cnt <= a_cnt - CW'(1);
        default: a_cnt <= a_cnt;
      endcase
      case ({b_push, fire})
        2'b10:   b_cnt <= b_cnt + CW'(1);
        2'b01:   b_cnt <= b_cnt - CW'(1);
        default: b_cnt <= b_cnt;
      endcase
      case ({fire, y_pop})
        2'b10:   y_cnt <= y_cnt + CW'(1);
        2'b01:   y_cnt <= y_cnt - CW'(1);
        default: y_cnt <= y_cnt;
      endcase
      if (wr_acc && bus.write_address == 3'd6) mode <= bus.write_data[1:0];
      if (rd_acc) bus.read_data <= rd_mux;
    end
  end

`ifdef OP_FIFO_ENGINE_ERR_EN
  logic [1:0] err_new;
  assign err_new = {bus.read_en && !bus.read_rdy, bus.write_en && !bus.write_rdy};

  // Read-to-clear drops old bits but keeps anything raised on the clearing edge.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      err_q <= 2'b00;
    else if (rd_acc && bus.read_address == 3'd7)
      err_q <= err_new;
    else
      err_q <= err_q | err_new;
  end
`else
  assign err_q = 2'b00;
`endif

endmodule

// File: tb/tb_op_fifo_engine.sv
// Bench for op_fifo_engine (DATA_W=8, DEPTH=4): mode table, FIFO fill/stall/drain,
// pointer wrap, same-edge MODE change, error register and mid-stream reset.
module tb_op_fifo_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  op_fifo_engine_if #(.DATA_W(8)) bus ();

  op_fifo_engine #(.DATA_W(8), .DEPTH(4)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_q [$];
  logic [1:0] cur_mode;
  int         total = 0;
  int         bad   = 0;

  function automatic logic [7:0] model_op(input logic [1:0] m, input logic [7:0] a,
                                          input logic [7:0] b);
    case (m)
      2'd0:    return a | b;
      2'd1:    return a & b;
      2'd2:    return a ^ b;
      default: return 8'((9'(a) + 9'(b)) % 256);
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected ready", name);
  endtask

  // All driver tasks start and end at a falling edge.
  task automatic wr(input logic [2:0] addr, input logic [7:0] data);
    int n = 0;
    bus.write_address = addr;
    bus.write_data    = data;
    #1;
    while (!bus.write_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.write_rdy) timeout("wr_rdy");
    bus.write_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.write_en = 1'b0;
  endtask

  task automatic raw_wr(input logic [2:0] addr, input logic [7:0] data);
    bus.write_address = addr;
    bus.write_data    = data;
    bus.write_en      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.write_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] addr, output logic [7:0] d);
    bus.read_address = addr;
    bus.read_en      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.read_en = 1'b0;
    d = bus.read_data;
  endtask

  task automatic rd_check(input string name, input logic [2:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    rd(addr, d);
    check(name, d, exp);
  endtask

  task automatic poll(input string name, input logic [2:0] addr, input logic [7:0] want);
    logic [7:0] d;
    int n = 0;
    do begin
      rd(addr, d);
      n++;
    end while (d !== want && n < 20);
    check(name, d, want);
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    wr(3'd4, a);
    wr(3'd5, b);
    exp_q.push_back(model_op(cur_mode, a, b));
  endtask

  task automatic pop_check(input string name);
    logic [7:0] d;
    int n = 0;
    bus.read_address = 3'd3;
    #1;
    while (!bus.read_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.read_rdy) timeout(name);
    rd(3'd3, d);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got 0x%02h expected no output", name, d);
    end else begin
      check(name, d, exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] av [6];
    logic [7:0] bv [6];

    vecs[0] = '{2'd0, 8'h0F, 8'hF0, 8'hFF};
    vecs[1] = '{2'd1, 8'hC3, 8'h5A, 8'h42};
    vecs[2] = '{2'd2, 8'hC3, 8'h5A, 8'h99};
    vecs[3] = '{2'd3, 8'hC3, 8'h5A, 8'h1D};
    vecs[4] = '{2'd3, 8'hFF, 8'h02, 8'h01};
    vecs[5] = '{2'd2, 8'hAA, 8'hAA, 8'h00};

    bus.write_address = 3'd0;
    bus.write_data    = 8'h00;
    bus.write_en      = 1'b0;
    bus.read_address  = 3'd0;
    bus.read_en       = 1'b0;
    cur_mode          = 2'd0;

    // Reset behaviour.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_write_rdy", {7'd0, bus.write_rdy}, 8'h00);
    check("rst_read_rdy", {7'd0, bus.read_rdy}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_read_data", bus.read_data, 8'h00);
    rd_check("rst_a_not_full", 3'd0, 8'h01);
    rd_check("rst_b_not_full", 3'd1, 8'h01);
    rd_check("rst_y_not_empty", 3'd2, 8'h00);
    rd_check("rst_mode", 3'd6, 8'h00);
    bus.read_address = 3'd3;
    #1;
    check("rst_y_read_rdy", {7'd0, bus.read_rdy}, 8'h00);
    @(negedge clk);

    // Mode table.
    for (int i = 0; i < 6; i++) begin
      wr(3'd6, {6'd0, vecs[i].mode});
      cur_mode = vecs[i].mode;
      wr(3'd4, vecs[i].a);
      wr(3'd5, vecs[i].b);
      exp_q.push_back(vecs[i].y);
      poll($sformatf("vec%0d_y_ready", i), 3'd2, 8'h01);
      pop_check($sformatf("vec%0d_y", i));
    end

    // A full, then engine stalls on full Y, then drain.
    wr(3'd6, 8'h03);
    cur_mode = 2'd3;
    for (int i = 0; i < 6; i++) begin
      av[i] = 8'($urandom_range(0, 255));
      bv[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 4; i++) wr(3'd4, av[i]);
    rd_check("a_full_status", 3'd0, 8'h00);
    bus.write_address = 3'd4;
    #1;
    check("a_full_write_rdy", {7'd0, bus.write_rdy}, 8'h00);
    @(negedge clk);
    wr(3'd5, bv[0]);
    exp_q.push_back(model_op(cur_mode, av[0], bv[0]));
    poll("a_not_full_after_fire", 3'd0, 8'h01);
    for (int i = 1; i < 4; i++) begin
      wr(3'd5, bv[i]);
      exp_q.push_back(model_op(cur_mode, av[i], bv[i]));
    end
    for (int i = 4; i < 6; i++) push_pair(av[i], bv[i]);
    idle(4);
    rd_check("y_full_ready", 3'd2, 8'h01);
    rd_check("a_stalled_not_full", 3'd0, 8'h01);
    for (int i = 0; i < 6; i++) pop_check($sformatf("drain1_%0d", i));
    rd_check("drain1_empty", 3'd2, 8'h00);

    // Second fill/drain wraps every pointer.
    wr(3'd6, 8'h02);
    cur_mode = 2'd2;
    for (int i = 0; i < 6; i++)
      push_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    idle(4);
    for (int i = 0; i < 6; i++) pop_check($sformatf("drain2_%0d", i));
    rd_check("drain2_empty", 3'd2, 8'h00);

    // MODE write on the same edge the engine fires an OR.
    wr(3'd6, 8'h00);
    wr(3'd4, 8'h0C);
    wr(3'd5, 8'h0A);
    wr(3'd6, 8'h02);
    exp_q.push_back(8'h0E);
    wr(3'd4, 8'h3C);
    wr(3'd5, 8'h0F);
    exp_q.push_back(8'h33);
    cur_mode = 2'd2;
    poll("mode_chg_ready", 3'd2, 8'h01);
    pop_check("mode_chg_old");
    pop_check("mode_chg_new");
    rd_check("mode_chg_mode", 3'd6, 8'h02);

    // Protocol errors: write to full A, read from empty Y.
    for (int i = 0; i < 4; i++) wr(3'd4, 8'(i + 1));
    raw_wr(3'd4, 8'h55);
    bus.read_address = 3'd3;
    bus.read_en      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.read_en = 1'b0;
`ifdef OP_FIFO_ENGINE_ERR_EN
    rd_check("err_first", 3'd7, 8'h03);
`else
    rd_check("err_first", 3'd7, 8'h00);
`endif
    rd_check("err_cleared", 3'd7, 8'h00);

    // Mid-stream reset discards A contents, Y result and MODE.
    wr(3'd5, 8'h01);
    poll("pre_rst_y_ready", 3'd2, 8'h01);
    rst_n = 1'b0;
    bus.read_address  = 3'd0;
    bus.write_address = 3'd0;
    #1;
    check("mid_rst_write_rdy", {7'd0, bus.write_rdy}, 8'h00);
    check("mid_rst_read_rdy", {7'd0, bus.read_rdy}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    cur_mode = 2'd0;
    check("mid_rst_read_data", bus.read_data, 8'h00);
    rd_check("mid_rst_a_not_full", 3'd0, 8'h01);
    rd_check("mid_rst_b_not_full", 3'd1, 8'h01);
    rd_check("mid_rst_y_not_empty", 3'd2, 8'h00);
    rd_check("mid_rst_mode", 3'd6, 8'h00);
    rd_check("mid_rst_err", 3'd7, 8'h00);
    push_pair(8'h0F, 8'h30);
    poll("post_rst_y_ready", 3'd2, 8'h01);
    pop_check("post_rst_y");
    rd_check("post_rst_empty", 3'd2, 8'h00);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
